// File: rtl/td4_program_memory_if.sv
// td4_program_memory_if: fetch interface between the program memory and the TD4 CPU core
//   pc        CPU program counter (master -> slave)
//   opcode    mem[pc][7:4]        (slave -> master)
//   immediate mem[pc][3:0]        (slave -> master)
//   exec_mode CPU execute enable  (slave -> master)
interface td4_program_memory_if;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       exec_mode;
  modport master (output pc, input opcode, immediate, exec_mode);
  modport slave (input pc, output opcode, immediate, exec_mode);
endinterface

// File: rtl/td4_program_memory.sv
// td4_program_memory: 16x8 TD4 program store, loaded nibble-serially from pins, gating CPU exec_mode
//   clk, rst_n        clock, asynchronous active-low reset
//   prog_en_i         load mode request level (async pin)
//   prog_strobe_i     nibble write strobe, rising edge used (async pin)
//   prog_nibble_i     nibble data, captured on the synchronized strobe edge
//   run_i             execute request level (async pin)
//   step_i            single-step pulse (async pin), present only with TD4_STEP_EN
//   fetch             slave side of the CPU fetch interface (pc in; opcode/immediate/exec_mode out)
//   load_addr_o       next entry to be written
//   prog_full_o       all entries written in the current load session
//   state_o           00 IDLE, 01 LOAD, 10 RUN
//   Optional feature macro: TD4_STEP_EN
module td4_program_memory #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_en_i,
  input  logic       prog_strobe_i,
  input  logic [3:0] prog_nibble_i,
  input  logic       run_i,
`ifdef TD4_STEP_EN
  input  logic       step_i,
`endif
  td4_program_memory_if.slave fetch,
  output logic [3:0] load_addr_o,
  output logic       prog_full_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] en_sq, run_sq, stb_sq;
  logic stb_prev_q, exec_q, full_q, phase_lo_q;
  logic [3:0] addr_q, hi_q;
  logic [7:0] mem_q [DEPTH];
  logic en_s, run_s, stb_rise, step_rise, wr_ok;
  assign en_s = en_sq[SYNC_STAGES-1];
  assign run_s = run_sq[SYNC_STAGES-1];
  assign stb_rise = stb_sq[SYNC_STAGES-1] & ~stb_prev_q;
`ifdef TD4_STEP_EN
  logic [SYNC_STAGES-1:0] step_sq;
  logic step_prev_q;
  assign step_rise = step_sq[SYNC_STAGES-1] & ~step_prev_q;
`else
  assign step_rise = 1'b0;
`endif
  // prog_en dominates; leaving LOAD always passes through IDLE
  always_comb state_d = en_s ? LOAD : (state_q == LOAD) ? IDLE : run_s ? RUN : IDLE;
  // the LOAD->IDLE transition wins over a coincident strobe edge; a full session ignores edges
  assign wr_ok = state_q == LOAD && en_s && stb_rise && !full_q;
  assign fetch.opcode = mem_q[fetch.pc][7:4];
  assign fetch.immediate = mem_q[fetch.pc][3:0];
  assign fetch.exec_mode = exec_q;
  assign load_addr_o = addr_q;
  assign prog_full_o = full_q;
  assign state_o = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sq <= '0;
      run_sq <= '0;
      stb_sq <= '0;
      stb_prev_q <= 1'b0;
`ifdef TD4_STEP_EN
      step_sq <= '0;
      step_prev_q <= 1'b0;
`endif
      state_q <= IDLE;
      exec_q <= 1'b0;
      addr_q <= 4'd0;
      full_q <= 1'b0;
      phase_lo_q <= 1'b0;
      hi_q <= 4'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      en_sq <= {en_sq[SYNC_STAGES-2:0], prog_en_i};
      run_sq <= {run_sq[SYNC_STAGES-2:0], run_i};
      stb_sq <= {stb_sq[SYNC_STAGES-2:0], prog_strobe_i};
      stb_prev_q <= stb_sq[SYNC_STAGES-1];
`ifdef TD4_STEP_EN
      step_sq <= {step_sq[SYNC_STAGES-2:0], step_i};
      step_prev_q <= step_sq[SYNC_STAGES-1];
`endif
      state_q <= state_d;
      // a step only fires when the FSM stays in IDLE, giving a single exec cycle
      exec_q <= state_d == RUN || (state_q == IDLE && state_d == IDLE && step_rise);
      if (state_q == LOAD && !en_s) begin
        addr_q <= 4'd0;
        full_q <= 1'b0;
        phase_lo_q <= 1'b0;
      end else if (wr_ok) begin
        phase_lo_q <= !phase_lo_q;
        if (!phase_lo_q) hi_q <= prog_nibble_i;
        else begin
          mem_q[addr_q] <= {hi_q, prog_nibble_i};
          addr_q <= addr_q + 4'd1;
          full_q <= addr_q == 4'd15;
        end
      end
    end
  end
endmodule

// File: tb/tb_td4_program_memory.sv
// tb_td4_program_memory: self-checking bench for td4_program_memory against a settled-state model
module tb_td4_program_memory;
  localparam int SS = 2;
  logic clk = 1'b0, rst_n = 1'b0, prog_en = 1'b0, prog_strobe = 1'b0, run = 1'b0;
  logic [3:0] prog_nibble = 4'h0, load_addr;
  logic prog_full;
  logic [1:0] state;
`ifdef TD4_STEP_EN
  logic step = 1'b0;
`endif
  td4_program_memory_if f();
  td4_program_memory #(.SYNC_STAGES(SS), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .prog_en_i(prog_en), .prog_strobe_i(prog_strobe),
    .prog_nibble_i(prog_nibble), .run_i(run),
`ifdef TD4_STEP_EN
    .step_i(step),
`endif
    .fetch(f), .load_addr_o(load_addr), .prog_full_o(prog_full), .state_o(state));
  always #5 clk = ~clk;
  logic [7:0] m_mem [16];
  logic [3:0] m_addr, m_hi;
  logic m_full, m_half;
  logic [1:0] m_state;
  int vectors = 0, miscompares = 0, ecnt = 0;
  bit chk = 0, sweep = 1;
  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_addr = 0; m_hi = 0; m_full = 0; m_half = 0; m_state = 2'b00;
  endfunction
  function automatic void m_levels();
    if (m_state == 2'b01 && !prog_en) begin m_addr = 0; m_full = 0; m_half = 0; end
    m_state = prog_en ? 2'b01 : run ? 2'b10 : 2'b00;
  endfunction
  always @(negedge clk) begin
    if (f.exec_mode === 1'b1) ecnt++;
    if (chk) begin
      cmp("opcode", 8'(f.opcode), 8'(m_mem[f.pc][7:4]));
      cmp("immediate", 8'(f.immediate), 8'(m_mem[f.pc][3:0]));
      cmp("exec_mode", 8'(f.exec_mode), 8'(m_state == 2'b10));
      cmp("state", 8'(state), 8'(m_state));
      cmp("load_addr", 8'(load_addr), 8'(m_addr));
      cmp("prog_full", 8'(prog_full), 8'(m_full));
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (sweep) f.pc = f.pc + 4'd1;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pins(input logic en, input logic rn);
    tick(1); chk = 0; prog_en = en; run = rn; tick(SS + 3); m_levels(); chk = 1;
  endtask
  task automatic nib(input logic [3:0] n);
    tick(1); chk = 0; prog_nibble = n; prog_strobe = 1; tick(SS + 2); prog_strobe = 0; tick(SS + 2);
    if (m_state == 2'b01 && !m_full) begin
      if (!m_half) begin m_hi = n; m_half = 1; end
      else begin m_mem[m_addr] = {m_hi, n}; m_full = m_addr == 4'd15; m_addr = m_addr + 4'd1; m_half = 0; end
    end
    chk = 1;
  endtask
  task automatic put_byte(input logic [7:0] b);
    nib(b[7:4]); nib(b[3:0]);
  endtask
  task automatic peek(input string name, input logic [3:0] p, input logic [7:0] exp);
    sweep = 0; f.pc = p; #1;
    cmp(name, {f.opcode, f.immediate}, exp);
    sweep = 1;
  endtask
  initial begin
    f.pc = 4'd0;
    m_reset();
    tick(3); rst_n = 1; tick(1); chk = 1;
    tick(20);
    cmp("rst_state", 8'(state), 8'h00);
    cmp("rst_exec", 8'(f.exec_mode), 8'h00);
    peek("rst_mem7", 4'd7, 8'h00);
    pins(1, 0);
    put_byte(8'hC3); put_byte(8'hA5);
    cmp("two_addr", 8'(load_addr), 8'd2);
    peek("two_mem1", 4'd1, 8'hA5);
    peek("two_mem0", 4'd0, 8'hC3);
    cmp("model_mem1", m_mem[1], 8'hA5);
    nib(4'h7); pins(0, 0); tick(6);
    peek("partial_mem2", 4'd2, 8'h00);
    pins(1, 0); put_byte(8'h12);
    peek("session_mem0", 4'd0, 8'h12);
    nib(4'h9);
    tick(1); chk = 0; prog_nibble = 4'h4; prog_strobe = 1; prog_en = 0; tick(SS + 3);
    prog_strobe = 0; tick(SS + 2); m_levels(); chk = 1;
    peek("exit_wins_mem1", 4'd1, 8'hA5);
    pins(1, 0);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] k;
      k = 4'(i);
      put_byte(i < 16 ? {k, ~k} : 8'hEE);
      if (i == 14) cmp("full_before16", 8'(prog_full), 8'h00);
    end
    cmp("full_flag", 8'(prog_full), 8'h01);
    cmp("full_addr", 8'(load_addr), 8'h00);
    peek("full_mem0", 4'd0, 8'h0F);
    peek("full_mem15", 4'd15, 8'hF0);
    cmp("model_mem0", m_mem[0], 8'h0F);
    pins(0, 0); tick(20);
    tick(1); chk = 0; run = 1;
    tick(SS); cmp("run_early", 8'(f.exec_mode), 8'h00);
    tick(1); cmp("run_exec", 8'(f.exec_mode), 8'h01); cmp("run_state", 8'(state), 8'h02);
    tick(2); m_levels(); chk = 1; tick(10);
    pins(1, 1);
    cmp("halt_state", 8'(state), 8'h01);
    cmp("halt_exec", 8'(f.exec_mode), 8'h00);
    pins(0, 1); tick(8); pins(0, 0);
`ifdef TD4_STEP_EN
    begin
      int e0;
      tick(1); chk = 0; e0 = ecnt;
      for (int i = 0; i < 3; i++) begin step = 1; tick(SS + 2); step = 0; tick(SS + 2); end
      cmp("step_idle_cnt", 8'(ecnt - e0), 8'd3);
      pins(1, 0); chk = 0; e0 = ecnt;
      for (int i = 0; i < 3; i++) begin step = 1; tick(SS + 2); step = 0; tick(SS + 2); end
      cmp("step_load_cnt", 8'(ecnt - e0), 8'd0);
      pins(0, 0);
    end
`endif
    pins(1, 0); put_byte(8'h5A); nib(4'h3);
    tick(1); chk = 0; rst_n = 0; #2;
    cmp("areset_state", 8'(state), 8'h00);
    cmp("areset_addr", 8'(load_addr), 8'h00);
    prog_en = 0; m_reset();
    tick(2); rst_n = 1; tick(SS + 3); chk = 1; tick(20);
    peek("areset_mem0", 4'd0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
